// File: rtl/instr_fetch_unit.sv
// Thumb instruction fetch stage: req/ack halfword fetch, prefetch FIFO, valid/ready hand-off to decode.
// Define IFU_BYPASS_EN for a zero-latency path from imem_rdata to decode when the FIFO is empty.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] next_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        target_q, target_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        fifo_instr_q [FIFO_DEPTH];
    logic [15:0]        fifo_instr_d [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]        fifo_pc_d    [FIFO_DEPTH];

    logic [31:0] branch_pc;
    logic        fifo_valid;
    logic        fetch_done;
    logic        bypass_hit;
    logic        push;
    logic        pop;

    assign branch_pc  = branch_target & ~32'd1;
    assign fifo_valid = (count_q != '0);
    assign fetch_done = (state_q == REQ) && imem_ack && !branch_valid;

`ifdef IFU_BYPASS_EN
    assign bypass_hit = !reset && fetch_done && (count_q == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word that decode takes immediately never occupies a FIFO slot.
    assign push = fetch_done && !(bypass_hit && instr_ready);
    assign pop  = fifo_valid && instr_ready && !branch_valid;

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = fifo_valid || bypass_hit;
    assign instr_out   = bypass_hit ? imem_rdata : fifo_instr_q[rd_ptr_q];
    assign instr_pc    = bypass_hit ? fetch_pc_q : fifo_pc_q[rd_ptr_q];
    assign next_pc     = instr_valid ? (instr_pc + 32'd2) : fetch_pc_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        if (branch_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d               = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        unique case (state_q)
            IDLE: begin
                if (branch_valid) begin
                    fetch_pc_d = branch_pc;
                    state_d    = REQ;
                end else if (count_q < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (branch_valid && imem_ack) begin
                    fetch_pc_d = branch_pc;
                end else if (branch_valid) begin
                    // The in-flight read cannot be cancelled; remember where to go once it completes.
                    target_d = branch_pc;
                    state_d  = DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd2;
                    state_d    = (count_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (branch_valid) begin
                    target_d = branch_pc;
                end
                if (imem_ack) begin
                    fetch_pc_d = branch_valid ? branch_pc : target_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            target_q     <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            // NOTE: the storage is reset (it is tiny) so instr_out/instr_pc read zero out of reset.
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            target_q     <= target_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

endmodule
